// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a controlling FSM (master) and the
// sequential binary-to-BCD converter (slave).
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
);
    logic                  start_i;
    logic [BIN_W-1:0]      bin_i;
    logic                  ready_o;
    logic                  done_o;
    logic [4*DIGITS-1:0]   bcd_o;
    logic                  ovf_o;
    logic [DIGITS-1:0]     blank_o;

    modport master (
        output start_i, bin_i,
        input  ready_o, done_o, bcd_o, ovf_o, blank_o
    );

    modport slave (
        input  start_i, bin_i,
        output ready_o, done_o, bcd_o, ovf_o, blank_o
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN enables the leading-zero blank mask.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    bin_to_bcd_seq_if.slave  bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic               ovf_sr_q, ovf_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [DIGITS-1:0]  blank_q, blank_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BIN_W-1:0]   bin_shift;
    logic               ovf_next;
    logic [DIGITS-1:0]  blank_calc;

    // One double-dabble iteration: per-digit add-3 without inter-digit carry,
    // then shift; the bit leaving the top digit is folded into the sticky overflow.
    always_comb begin
        adj = bcd_sr_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (bcd_sr_q[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = bcd_sr_q[4*k +: 4] + 4'd3;
            end
        end
        ovf_next  = ovf_sr_q | adj[BCD_W-1];
        bcd_shift = {adj[BCD_W-2:0], bin_sr_q[BIN_W-1]};
        bin_shift = {bin_sr_q[BIN_W-2:0], 1'b0};
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic higher_zero;

    always_comb begin
        blank_calc  = '0;
        higher_zero = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            higher_zero   = higher_zero & (bcd_shift[4*k +: 4] == 4'd0);
            blank_calc[k] = higher_zero & ~ovf_next;
        end
    end
`else
    always_comb begin
        blank_calc = '0;
    end
`endif

    always_comb begin
        state_d  = state_q;
        bin_sr_d = bin_sr_q;
        bcd_sr_d = bcd_sr_q;
        ovf_sr_d = ovf_sr_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        ovf_d    = ovf_q;
        blank_d  = blank_q;
        case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    bin_sr_d = bus.bin_i;
                    bcd_sr_d = '0;
                    ovf_sr_d = 1'b0;
                    cnt_d    = CNT_W'(BIN_W);
                    state_d  = OP;
                end
            end
            OP: begin
                bin_sr_d = bin_shift;
                bcd_sr_d = bcd_shift;
                ovf_sr_d = ovf_next;
                cnt_d    = cnt_q - CNT_W'(1);
                // Last iteration publishes straight to the result registers.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = bcd_shift;
                    ovf_d   = ovf_next;
                    blank_d = blank_calc;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            bin_sr_q <= '0;
            bcd_sr_q <= '0;
            ovf_sr_q <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            ovf_q    <= 1'b0;
            blank_q  <= '0;
        end else begin
            state_q  <= state_d;
            bin_sr_q <= bin_sr_d;
            bcd_sr_q <= bcd_sr_d;
            ovf_sr_q <= ovf_sr_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            ovf_q    <= ovf_d;
            blank_q  <= blank_d;
        end
    end

    assign bus.ready_o = (state_q == IDLE);
    assign bus.done_o  = (state_q == DONE);
    assign bus.bcd_o   = bcd_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.blank_o = blank_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 13-bit and a 14-bit instance,
// table-driven vectors, a result scoreboard and hand-written corner sequences.
module tb_bin_to_bcd_seq;
    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank_en;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   done_cnt_a;
    int   done_cnt_b;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t mon_a;
    exp_t mon_b;

    bin_to_bcd_seq_if #(.BIN_W(13), .DIGITS(4)) bus_a ();
    bin_to_bcd_seq_if #(.BIN_W(14), .DIGITS(4)) bus_b ();

    bin_to_bcd_seq #(.BIN_W(13), .DIGITS(4)) dut_a (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus_a)
    );

    bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (
        .clk_i    (clk),
        .reset_ni (rst_n),
        .bus      (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] blank_exp(input logic [3:0] b);
`ifdef LEADING_ZERO_BLANK_EN
        return b;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic rdy(input bit which);
        return which ? bus_b.ready_o : bus_a.ready_o;
    endfunction

    function automatic logic dn(input bit which);
        return which ? bus_b.done_o : bus_a.done_o;
    endfunction

    task automatic drive(input bit which, input logic s, input logic [13:0] bin);
        if (which) begin
            bus_b.start_i = s;
            bus_b.bin_i   = bin;
        end else begin
            bus_a.start_i = s;
            bus_a.bin_i   = bin[12:0];
        end
    endtask

    task automatic pushExp(input bit which, input exp_t e);
        if (which) exp_b.push_back(e);
        else       exp_a.push_back(e);
    endtask

    task automatic waitReady(input bit which);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (rdy(which)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) failNow("wait_ready");
    endtask

    task automatic waitDone(input bit which, output int lat);
        bit ok;
        ok  = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (dn(which)) begin
                lat = k;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) failNow("wait_done");
    endtask

    // Launch one conversion, checking handshake timing around it.
    task automatic applyStimulus(input bit which, input logic [13:0] bin, input exp_t e);
        int lat;
        waitReady(which);
        @(negedge clk);
        drive(which, 1'b1, bin);
        pushExp(which, e);
        @(posedge clk);
        #1;
        checkOutput("ready_drop", 32'(rdy(which)), 32'd0);
        drive(which, 1'b0, bin);
        waitDone(which, lat);
        checkOutput("latency", 32'(lat), which ? 32'd14 : 32'd13);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", 32'(dn(which)), 32'd0);
        checkOutput("ready_back", 32'(rdy(which)), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus_a.done_o) begin
            done_cnt_a++;
            if (exp_a.size() == 0) begin
                failNow("unexpected_done_a");
            end else begin
                mon_a = exp_a.pop_front();
                checkOutput("bcd_a", 32'(bus_a.bcd_o), 32'(mon_a.bcd));
                checkOutput("ovf_a", 32'(bus_a.ovf_o), 32'(mon_a.ovf));
                checkOutput("blank_a", 32'(bus_a.blank_o), 32'(mon_a.blank));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_b.done_o) begin
            done_cnt_b++;
            if (exp_b.size() == 0) begin
                failNow("unexpected_done_b");
            end else begin
                mon_b = exp_b.pop_front();
                checkOutput("bcd_b", 32'(bus_b.bcd_o), 32'(mon_b.bcd));
                checkOutput("ovf_b", 32'(bus_b.ovf_o), 32'(mon_b.ovf));
                checkOutput("blank_b", 32'(bus_b.blank_o), 32'(mon_b.blank));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vec_a[10];
        vec_t vec_b[4];
        exp_t e;
        int   lat;
        int   gap;
        int   dn_before;

        vec_a[0] = '{14'd0,    16'h0000, 1'b0, 4'b1110};
        vec_a[1] = '{14'd1234, 16'h1234, 1'b0, 4'b0000};
        vec_a[2] = '{14'd8191, 16'h8191, 1'b0, 4'b0000};
        vec_a[3] = '{14'd42,   16'h0042, 1'b0, 4'b1100};
        vec_a[4] = '{14'd1000, 16'h1000, 1'b0, 4'b0000};
        vec_a[5] = '{14'd7,    16'h0007, 1'b0, 4'b1110};
        vec_a[6] = '{14'd305,  16'h0305, 1'b0, 4'b1000};
        vec_a[7] = '{14'd5000, 16'h5000, 1'b0, 4'b0000};
        vec_a[8] = '{14'd90,   16'h0090, 1'b0, 4'b1100};
        vec_a[9] = '{14'd6789, 16'h6789, 1'b0, 4'b0000};

        vec_b[0] = '{14'd12345, 16'h2345, 1'b1, 4'b0000};
        vec_b[1] = '{14'd16383, 16'h6383, 1'b1, 4'b0000};
        vec_b[2] = '{14'd9999,  16'h9999, 1'b0, 4'b0000};
        vec_b[3] = '{14'd10000, 16'h0000, 1'b1, 4'b0000};

        checks     = 0;
        errors     = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
        rst_n      = 1'b0;
        drive(1'b0, 1'b0, 14'd0);
        drive(1'b1, 1'b0, 14'd0);

        #1;
        checkOutput("reset_ready", 32'(bus_a.ready_o), 32'd1);
        checkOutput("reset_done", 32'(bus_a.done_o), 32'd0);
        checkOutput("reset_bcd", 32'(bus_a.bcd_o), 32'd0);
        checkOutput("reset_ovf", 32'(bus_a.ovf_o), 32'd0);
        checkOutput("reset_blank", 32'(bus_a.blank_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            e = '{vec_a[i].bcd, vec_a[i].ovf, blank_exp(vec_a[i].blank_en)};
            applyStimulus(1'b0, vec_a[i].bin, e);
        end
        for (int i = 0; i < 4; i++) begin
            e = '{vec_b[i].bcd, vec_b[i].ovf, blank_exp(vec_b[i].blank_en)};
            applyStimulus(1'b1, vec_b[i].bin, e);
        end

        // start held high: restart on return to IDLE, bin_i changed after accept
        waitReady(1'b0);
        @(negedge clk);
        drive(1'b0, 1'b1, 14'd100);
        pushExp(1'b0, '{16'h0100, 1'b0, blank_exp(4'b1000)});
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 14'd200);
        pushExp(1'b0, '{16'h0200, 1'b0, blank_exp(4'b1000)});
        gap = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus_a.ready_o) begin
                gap = k;
                break;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("restart_period", 32'(gap + 1), 32'd15);
        checkOutput("restart_ready_low", 32'(bus_a.ready_o), 32'd0);
        drive(1'b0, 1'b0, 14'd0);
        waitDone(1'b0, lat);
        checkOutput("restart_latency", 32'(lat), 32'd13);
        @(posedge clk);
        #1;

        // second start during OP is ignored
        dn_before = done_cnt_a;
        @(negedge clk);
        drive(1'b0, 1'b1, 14'd4567);
        pushExp(1'b0, '{16'h4567, 1'b0, blank_exp(4'b0000)});
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 14'd0);
        repeat (4) @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 14'd99);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 14'd0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("ignored_start_dones", 32'(done_cnt_a - dn_before), 32'd1);
        checkOutput("hold_bcd_idle", 32'(bus_a.bcd_o), 32'h4567);
        checkOutput("hold_ready", 32'(bus_a.ready_o), 32'd1);

        // result holds during the following conversion
        @(negedge clk);
        drive(1'b0, 1'b1, 14'd1234);
        pushExp(1'b0, '{16'h1234, 1'b0, blank_exp(4'b0000)});
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 14'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("hold_bcd_busy", 32'(bus_a.bcd_o), 32'h4567);
        waitDone(1'b0, lat);
        checkOutput("hold_latency", 32'(lat), 32'd7);
        @(posedge clk);
        #1;

        // reset mid-conversion aborts without done
        @(negedge clk);
        drive(1'b0, 1'b1, 14'd777);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 14'd0);
        repeat (5) @(posedge clk);
        #2;
        checkOutput("abort_busy", 32'(bus_a.ready_o), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(bus_a.ready_o), 32'd1);
        checkOutput("abort_done", 32'(bus_a.done_o), 32'd0);
        checkOutput("abort_bcd", 32'(bus_a.bcd_o), 32'd0);
        checkOutput("abort_ovf", 32'(bus_a.ovf_o), 32'd0);
        checkOutput("abort_blank", 32'(bus_a.blank_o), 32'd0);
        dn_before = done_cnt_a;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_no_done", 32'(done_cnt_a - dn_before), 32'd0);
        applyStimulus(1'b0, 14'd42, '{16'h0042, 1'b0, blank_exp(4'b1100)});

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty_a", 32'(exp_a.size()), 32'd0);
        checkOutput("scoreboard_empty_b", 32'(exp_b.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
